// File: rtl/exec_sequencer_pkg.sv
// Shared definitions for the execution sequencer.
//
// Purpose
//   Holds the 2-bit state encoding that the sequencer drives on its state
//   output. Board-level logic (status LEDs, 7-segment display) imports the
//   same package, so the codes cannot drift apart.
//
// Contents
//   seq_state_e      : IDLE=00, STEP=01, RUN=10, HALT=11
//   SEQ_STATE_W      : width of the state code
//   state_is_active  : helper, 1 when the datapath may still be clocked

package exec_sequencer_pkg;

  localparam int SEQ_STATE_W = 2;

  typedef enum logic [SEQ_STATE_W-1:0] {
    ST_IDLE = 2'b00,
    ST_STEP = 2'b01,
    ST_RUN  = 2'b10,
    ST_HALT = 2'b11
  } seq_state_e;

  // HALT is the only state from which no further cpu_en can be issued.
  function automatic logic state_is_active(input seq_state_e s);
    return (s != ST_HALT);
  endfunction

endpackage

// File: rtl/exec_sequencer_if.sv
// Board/datapath-facing signal bundle of the execution sequencer.
//
// Purpose
//   Groups the raw operator inputs, the PC feedback from the datapath and the
//   sequencer's status outputs into one interface.
//
// Signals
//   step_btn   : raw step push-button (asynchronous, bouncy)
//   run_sw     : raw run switch (asynchronous, bouncy), 1 = free-run
//   pc         : current (pre-update) program counter value
//   cpu_en     : datapath clock enable
//   state      : sequencer state code (see exec_sequencer_pkg)
//   halted     : 1 while the sequencer is in HALT
//   step_count : saturating number of cpu_en pulses since reset
//
// Handshake contract: there is no back-pressure. cpu_en is a registered
// single-cycle strobe; the datapath must advance PC/RegA/RegB exactly once
// on every rising clk edge that ends a cycle with cpu_en=1, and pc must show
// the pre-advance value during that cycle.
//
// Modports
//   master : board/datapath side (drives inputs, observes status)
//   slave  : sequencer side

interface exec_sequencer_if #(
  parameter int PC_W  = 8,
  parameter int CNT_W = 16
);

  logic             step_btn;
  logic             run_sw;
  logic [PC_W-1:0]  pc;
  logic             cpu_en;
  logic [1:0]       state;
  logic             halted;
  logic [CNT_W-1:0] step_count;

  modport master (
    output step_btn,
    output run_sw,
    output pc,
    input  cpu_en,
    input  state,
    input  halted,
    input  step_count
  );

  modport slave (
    input  step_btn,
    input  run_sw,
    input  pc,
    output cpu_en,
    output state,
    output halted,
    output step_count
  );

endinterface

// File: rtl/exec_sequencer_debouncer.sv
// Synchroniser + debouncer for one raw mechanical input.
//
// Purpose
//   Brings an asynchronous, bouncy input into the clk domain through a 2-FF
//   synchroniser and only lets the filtered output change after the
//   synchronised value has disagreed with it for DEBOUNCE_CYCLES consecutive
//   cycles. Raw edge to stable edge latency is 2 + DEBOUNCE_CYCLES cycles.
//
// Ports
//   clk      : board clock
//   rst      : asynchronous reset, active-high (all state cleared to 0)
//   raw_i    : raw asynchronous input
//   stable_o : debounced level

module exec_sequencer_debouncer #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_i,
  output logic stable_o
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          meta_q;
  logic          sync_q;
  logic          stable_q;
  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q   <= 1'b0;
      sync_q   <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      meta_q <= raw_i;
      sync_q <= meta_q;
      // Any cycle of agreement restarts the count, so only an unbroken run
      // of DEBOUNCE_CYCLES disagreeing samples flips the output.
      if (sync_q == stable_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_LAST) begin
        stable_q <= sync_q;
        cnt_q    <= '0;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

  assign stable_o = stable_q;

endmodule

// File: rtl/exec_sequencer.sv
// Execution sequencer for the accumulator CPU.
//
// Purpose
//   Replaces "switch as clock" with a single board clock plus a one-cycle
//   clock enable (cpu_en) for PC, RegA and RegB. Supports single-step from a
//   debounced button, free-run at one instruction every RUN_DIV cycles from a
//   debounced switch, and a sticky halt once an instruction is executed with
//   pc == HALT_PC.
//
// Parameters
//   DEBOUNCE_CYCLES : stable cycles needed before a debounced input changes
//   RUN_DIV         : clk cycles between cpu_en pulses in RUN
//   PC_W            : width of pc
//   HALT_PC         : an instruction executed at this address halts
//   CNT_W           : width of step_count
//
// Ports
//   clk : board clock, all state on posedge
//   rst : asynchronous reset, active-high
//   bus : exec_sequencer_if.slave (step_btn, run_sw, pc in;
//         cpu_en, state, halted, step_count out)

module exec_sequencer
  import exec_sequencer_pkg::*;
#(
  parameter int              DEBOUNCE_CYCLES = 50000,
  parameter int              RUN_DIV         = 5000000,
  parameter int              PC_W            = 8,
  parameter logic [PC_W-1:0] HALT_PC         = {PC_W{1'b1}},
  parameter int              CNT_W           = 16
) (
  input  logic              clk,
  input  logic              rst,
  exec_sequencer_if.slave   bus
);

  localparam int               DIV_W    = $clog2(RUN_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RUN_DIV - 1);

  // ---------------------------------------------------------------------
  // Debounced operator inputs
  // ---------------------------------------------------------------------
  logic step_db;
  logic run_db;
  logic step_prev_q;
  logic step_press;

  exec_sequencer_debouncer #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_db_step (
    .clk      (clk),
    .rst      (rst),
    .raw_i    (bus.step_btn),
    .stable_o (step_db)
  );

  exec_sequencer_debouncer #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_db_run (
    .clk      (clk),
    .rst      (rst),
    .raw_i    (bus.run_sw),
    .stable_o (run_db)
  );

  // High for exactly the first cycle in which the debounced button is high.
  assign step_press = step_db & ~step_prev_q;

  // ---------------------------------------------------------------------
  // Sequencer FSM, run divider, halt compare and pulse counter
  // ---------------------------------------------------------------------
  seq_state_e       state_q;
  logic             cpu_en_q;
  logic             halted_q;
  logic [DIV_W-1:0] div_q;
  logic [CNT_W-1:0] cnt_q;
  logic             halt_hit;

  // The instruction executing in a cpu_en cycle is the one at the current
  // (pre-advance) pc, so the halt decision is taken at the edge that ends
  // the enable cycle.
  assign halt_hit = cpu_en_q && (bus.pc == HALT_PC);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cpu_en_q    <= 1'b0;
      halted_q    <= 1'b0;
      div_q       <= '0;
      cnt_q       <= '0;
      step_prev_q <= 1'b0;
    end else begin
      step_prev_q <= step_db;
      cpu_en_q    <= 1'b0;

      // Saturating count of issued pulses.
      if (cpu_en_q && (cnt_q != {CNT_W{1'b1}})) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end

      if (state_is_active(state_q)) begin
        if (halt_hit) begin
          // Halt wins over a simultaneous run-switch drop.
          state_q  <= ST_HALT;
          halted_q <= 1'b1;
          div_q    <= '0;
        end else begin
          case (state_q)
            ST_IDLE: begin
              // RUN has priority; a press arriving together with the run
              // switch is discarded.
              if (run_db) begin
                state_q <= ST_RUN;
                div_q   <= '0;
              end else if (step_press) begin
                state_q  <= ST_STEP;
                cpu_en_q <= 1'b1;
              end
            end

            ST_STEP: begin
              // One enable cycle only; the halt compare above covers the
              // HALT_PC case.
              state_q <= ST_IDLE;
            end

            ST_RUN: begin
              // Leaving RUN outranks a divider tick; step_press is ignored.
              if (!run_db) begin
                state_q <= ST_IDLE;
                div_q   <= '0;
              end else if (div_q == DIV_LAST) begin
                div_q    <= '0;
                cpu_en_q <= 1'b1;
              end else begin
                div_q <= div_q + DIV_W'(1);
              end
            end

            default: begin
              state_q <= ST_IDLE;
            end
          endcase
        end
      end
    end
  end

  assign bus.cpu_en     = cpu_en_q;
  assign bus.state      = state_q;
  assign bus.halted     = halted_q;
  assign bus.step_count = cnt_q;

endmodule
